sne_tcdm_stream_reader: RTL and testbench
=========================================

# sne_tcdm_stream_reader

Read-side TCDM streamer for the SNE engine slices. It fetches a programmed sequence of 32-bit words from cluster TCDM using the `sne_pkg` TCDM request/response structs. Words are buffered in a local FIFO of `sne_pkg::FC_FIFO_DEPTH` entries and presented on a valid/ready stream to the downstream engine stage. One instance is used per streamer (`sne_pkg::STREAMERS`) and configured from the `reg_req_t`/`reg_rsp_t` register file.

## Interface
Parameters:
- `FIFO_DEPTH`, default `sne_pkg::FC_FIFO_DEPTH` (10): output buffer entries; legal range ≥2.
- `LEN_WIDTH`, default 16: width of the word-count field.

Ports (clock domain: single clock; reset is synchronous, active-high):
- `clk_i`  in  1  system clock
- `rst_i`  in  1  synchronous active-high reset
- `start_i`  in  1  one-cycle start pulse; sampled only in IDLE
- `base_addr_i`  in  32  byte address of first word; bits [1:0] ignored (treated as 0)
- `stride_i`  in  32  byte increment between words; unsigned, address wraps mod 2^32
- `len_i`  in  LEN_WIDTH  number of words to read
- `busy_o`  out  1  high from the cycle after an accepted start until done
- `done_o`  out  1  one-cycle completion pulse
- `err_o`  out  1  sticky error flag; cleared on the next accepted start
- `tcdm_req_o`  out  `tcdm_req_t`  TCDM request
- `tcdm_rsp_i`  in  `tcdm_rsp_t`  TCDM response
- `data_o`  out  32  stream data
- `valid_o`  out  1  stream valid
- `ready_i`  in  1  stream ready

## Operation
- Start capture: `base_addr_i`, `stride_i` and `len_i` are latched on the accepted start. Later changes to these inputs have no effect until the next start.
- FSM states:
  - IDLE: waits for `start_i`. Goes to ISSUE if `len_i`≠0. If `len_i`=0, goes to DONE.
  - ISSUE: issues requests until `issued`==`len`, then goes to DRAIN.
  - DRAIN: waits until `inflight`==0 and the FIFO is empty, then goes to DONE.
  - DONE: asserts `done_o` for 1 cycle, then returns to IDLE.
- Request fields:
  - `req`=1 while in ISSUE and the credit check passes.
  - `add` = `base + issued*stride`, computed as a running accumulator with 32-bit wrap.
  - `wen`=1 (read), `be`=4'hF, `wdata`=0.
- Handshake: a request is consumed when `req && gnt`. While `req && !gnt`, all request fields hold stable and `req` does not drop.
- Response: `r_valid` arrives exactly 1 cycle after the granted cycle. `r_rdata` is pushed into the FIFO. `r_opc`=1 sets `err_o`, and the data is still pushed.
- Credit rule: assert `req` only when `fifo_count + inflight < FIFO_DEPTH`. `inflight` counts granted requests without a response so far (0 or 1). This guarantees the FIFO never overflows.
- Spurious response: `r_valid` with `inflight`==0 is discarded and sets `err_o`.
- Output stream: `data_o`/`valid_o` come from the FIFO head and pop on `valid_o && ready_i`. Simultaneous push and pop in one cycle are supported and leave the count unchanged.
- Start while busy: ignored.
- Reset: may be asserted at any time. Outstanding TCDM responses after reset are ignored and do not set `err_o`.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `err_o`=0, `valid_o`=0, `data_o`=0, and all `tcdm_req_o` fields 0. These take effect on the edge at which `rst_i` is sampled high.
- Start at edge 0 gives `busy_o`=1 and the first `req`=1 in cycle 1. With `gnt`=1, `r_valid` comes in cycle 2 and `valid_o`=1 in cycle 3. The FIFO is registered, not fall-through.
- Throughput: 1 word/cycle sustained when `gnt` and `ready_i` stay high.
- `done_o` and `busy_o`→0 occur in the cycle after the final pop. `len`=0 gives `done_o` in cycle 1 and `busy_o` stays 0.
- Backpressure: with `ready_i`=0, at most FIFO_DEPTH words are granted before `req` deasserts.

## Test plan
- Contiguous read: base=0x1000, stride=4, len=8, `gnt`/`ready_i` always 1. Addresses are 0x1000..0x101C. Data arrives in order on cycles 3..10. `done_o` at cycle 11.
- Stalled grant: `gnt` low for 3 cycles on the 2nd request. `add`=0x1004 and `req` stay stable through the stall, with no duplicate or missing words.
- Backpressure: len=20, `ready_i`=0. Exactly 10 grants, then `req`=0. Releasing `ready_i` yields all 20 words in order.
- Wrap and zero length: base=0xFFFFFFF8, stride=8, len=3 gives addresses 0xFFFFFFF8, 0x0, 0x8. len=0 gives `done_o` after 1 cycle with no request.
- Errors and mid-op reset: `r_opc`=1 on word 2 sets `err_o` until the next start. `rst_i` asserted while 1 request is in flight gives all outputs 0 next cycle, and the stale `r_valid` is ignored.

Source files
------------

// File: rtl/sne_tcdm_stream_reader.sv
// Read-side TCDM streamer: fetches a strided sequence of 32-bit words from TCDM
// and presents them on a valid/ready stream through a small registered FIFO.

package sne_pkg;
  localparam int unsigned FC_FIFO_DEPTH = 10;
  localparam int unsigned STREAMERS     = 4;

  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] wdata;
  } tcdm_req_t;

  typedef struct packed {
    logic        gnt;
    logic        r_valid;
    logic [31:0] r_rdata;
    logic        r_opc;
  } tcdm_rsp_t;
endpackage

// state | meaning
// IDLE  | waiting for a start pulse; configuration inputs are sampled here
// ISSUE | sending read requests while FIFO credit allows
// DRAIN | all requests granted; waiting for last response and FIFO to empty
// DONE  | one-cycle completion pulse
module sne_tcdm_stream_reader #(
  parameter int unsigned FIFO_DEPTH = sne_pkg::FC_FIFO_DEPTH,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [31:0]           base_addr_i,
  input  logic [31:0]           stride_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output sne_pkg::tcdm_req_t    tcdm_req_o,
  input  sne_pkg::tcdm_rsp_t    tcdm_rsp_i,
  output logic [31:0]           data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]          addr_q;
  logic [31:0]          stride_q;
  logic [LEN_WIDTH-1:0] remaining_q;
  logic                 inflight_q, inflight_d;
  logic                 drop_rsp_q;
  logic                 err_q;

  logic [31:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [CNT_W:0]       occupancy;
  logic                 credit_ok;
  logic                 req;
  logic                 grant;
  logic                 start_ok;
  logic                 rsp_valid;
  logic                 push;
  logic                 pop;
  logic                 spurious;

  // Occupancy includes the outstanding request so a late response always fits.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign credit_ok = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
  assign req       = (state_q == S_ISSUE) && credit_ok;
  assign grant     = req && tcdm_rsp_i.gnt;
  assign start_ok  = (state_q == S_IDLE) && start_i;

  // Responses to requests granted around a reset are dropped for one cycle.
  assign rsp_valid = tcdm_rsp_i.r_valid && !drop_rsp_q;
  assign push      = rsp_valid && inflight_q;
  assign spurious  = rsp_valid && !inflight_q;
  assign valid_o   = (count_q != '0);
  assign pop       = valid_o && ready_i;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (grant) begin
      inflight_d = 1'b1;
    end else if (push) begin
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (len_i == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (grant && (remaining_q == LEN_WIDTH'(1))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Look at next-cycle FIFO state so done follows the final pop directly.
        if (!inflight_d && (count_d == '0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      stride_q    <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      drop_rsp_q  <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      drop_rsp_q <= 1'b0;
      inflight_q <= inflight_d;
      if (start_ok) begin
        addr_q      <= base_addr_i & 32'hFFFF_FFFC;
        stride_q    <= stride_i;
        remaining_q <= len_i;
      end else if (grant) begin
        addr_q      <= addr_q + stride_q;
        remaining_q <= remaining_q - LEN_WIDTH'(1);
      end
      if (start_ok) begin
        err_q <= 1'b0;
      end else if ((push && tcdm_rsp_i.r_opc) || spurious) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= tcdm_rsp_i.r_rdata;
    end
  end

  assign data_o = valid_o ? mem[rd_ptr_q] : '0;
  assign busy_o = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done_o = (state_q == S_DONE);
  assign err_o  = err_q;

  always_comb begin
    tcdm_req_o = '0;
    if (state_q == S_ISSUE) begin
      tcdm_req_o.req = req;
      tcdm_req_o.add = addr_q;
      tcdm_req_o.wen = 1'b1;
      tcdm_req_o.be  = 4'hF;
    end
  end

endmodule

// File: tb/tb_sne_tcdm_stream_reader.sv
// Scoreboard bench: a TCDM responder and stream monitor check the DUT against
// expected address/data queues computed arithmetically at each start.

module tb_sne_tcdm_stream_reader;
  import sne_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [31:0] stride_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o, err_o;
  tcdm_req_t   tcdm_req_o;
  tcdm_rsp_t   tcdm_rsp_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i = 1'b0;

  always #5 clk_i = ~clk_i;

  sne_tcdm_stream_reader dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .stride_i    (stride_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .tcdm_req_o  (tcdm_req_o),
    .tcdm_rsp_i  (tcdm_rsp_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] salt = 32'h0;
  int gnt_mode = 0;   // 0 always, 1 random, 2 stall second request 3 cycles
  int rdy_mode = 1;   // 0 never, 1 always, 2 random
  int grants = 0;
  int stall_cnt = 0;
  int opc_idx = -1;

  int r_done, r_first;
  logic r_busy1, r_req1, r_err1, r_busy_done, r_err_done;
  logic [31:0] r_add1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return ((a ^ salt) * 32'h9E37_79B1) + 32'h0123_4567;
  endfunction

  // TCDM slave: answers each grant one cycle later, drives gnt and ready.
  initial begin
    logic g;
    logic [31:0] ga;
    logic opc_flag;
    logic prev_stall;
    logic [31:0] stall_add;
    prev_stall = 1'b0;
    stall_add = '0;
    tcdm_rsp_i = '0;
    forever begin
      @(negedge clk_i);
      g = tcdm_req_o.req && tcdm_rsp_i.gnt;
      ga = tcdm_req_o.add;
      if (!rst_i) begin
        if (prev_stall) begin
          chk("stall_req_held", {31'b0, tcdm_req_o.req}, 32'd1);
          chk("stall_add_held", tcdm_req_o.add, stall_add);
        end
        prev_stall = tcdm_req_o.req && !tcdm_rsp_i.gnt;
        stall_add = tcdm_req_o.add;
        if (g) begin
          if (exp_addr.size() == 0) chk("unexpected_grant", 32'd1, 32'd0);
          else chk("grant_addr", ga, exp_addr.pop_front());
        end
      end else begin
        prev_stall = 1'b0;
      end
      if (tcdm_req_o.req && !tcdm_rsp_i.gnt && grants == 1) stall_cnt++;
      opc_flag = g && (grants == opc_idx);
      if (g) grants++;
      @(posedge clk_i);
      #1;
      tcdm_rsp_i.r_valid = g;
      tcdm_rsp_i.r_rdata = g ? word_at(ga) : 32'h0;
      tcdm_rsp_i.r_opc   = opc_flag;
      case (gnt_mode)
        0:       tcdm_rsp_i.gnt = 1'b1;
        1:       tcdm_rsp_i.gnt = ($urandom_range(0, 3) != 0);
        default: tcdm_rsp_i.gnt = !(grants == 1 && stall_cnt < 3);
      endcase
      case (rdy_mode)
        0:       ready_i = 1'b0;
        1:       ready_i = 1'b1;
        default: ready_i = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Stream monitor.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i && valid_o && ready_i) begin
        if (exp_data.size() == 0) chk("unexpected_word", 32'd1, 32'd0);
        else chk("stream_data", data_o, exp_data.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns just after the edge that accepted start (cycle 1).
  task automatic start_op(input logic [31:0] b, input logic [31:0] s, input logic [15:0] l);
    logic [31:0] a;
    salt = $urandom;
    for (int i = 0; i < int'(l); i++) begin
      a = (b & 32'hFFFF_FFFC) + (32'(i) * s);
      exp_addr.push_back(a);
      exp_data.push_back(word_at(a));
    end
    grants = 0;
    stall_cnt = 0;
    base_addr_i = b;
    stride_i = s;
    len_i = l;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    base_addr_i = $urandom;
    stride_i = $urandom;
    len_i = 16'($urandom);
  endtask

  task automatic wait_done(input int limit);
    int cyc;
    cyc = 0;
    r_done = -1;
    r_first = -1;
    while (r_done < 0 && cyc < limit) begin
      @(negedge clk_i);
      cyc++;
      if (cyc == 1) begin
        r_busy1 = busy_o;
        r_req1 = tcdm_req_o.req;
        r_add1 = tcdm_req_o.add;
        r_err1 = err_o;
      end
      if (valid_o && r_first < 0) r_first = cyc;
      if (done_o) begin
        r_done = cyc;
        r_busy_done = busy_o;
        r_err_done = err_o;
      end
    end
    if (r_done < 0) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [15:0] l;
    logic [31:0] s;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_req", {31'b0, tcdm_req_o.req}, 32'd0);
    chk("rst_add", tcdm_req_o.add, 32'd0);
    chk("rst_wen_be", {27'b0, tcdm_req_o.wen, tcdm_req_o.be}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    idle(3);

    // Contiguous read with full throughput.
    start_op(32'h1000, 32'd4, 16'd8);
    wait_done(60);
    chk("contig_busy_c1", {31'b0, r_busy1}, 32'd1);
    chk("contig_req_c1", {31'b0, r_req1}, 32'd1);
    chk("contig_add_c1", r_add1, 32'h1000);
    chk("contig_first_valid", r_first, 32'd3);
    chk("contig_done_cycle", r_done, 32'd11);
    chk("contig_busy_at_done", {31'b0, r_busy_done}, 32'd0);
    chk("contig_words_left", exp_data.size(), 32'd0);
    idle(2);

    // Zero length.
    start_op(32'h2000, 32'd4, 16'd0);
    wait_done(10);
    chk("len0_done_cycle", r_done, 32'd1);
    chk("len0_busy_c1", {31'b0, r_busy1}, 32'd0);
    chk("len0_req_c1", {31'b0, r_req1}, 32'd0);
    chk("len0_grants", grants, 32'd0);
    idle(2);

    // Stalled grant on the second request.
    gnt_mode = 2;
    idle(2);
    start_op(32'h1000, 32'd4, 16'd4);
    wait_done(60);
    chk("stall_stall_cycles", stall_cnt, 32'd3);
    chk("stall_words_left", exp_data.size(), 32'd0);
    chk("stall_addrs_left", exp_addr.size(), 32'd0);
    gnt_mode = 0;
    idle(2);

    // Backpressure, with a start pulse while busy that must be ignored.
    rdy_mode = 0;
    idle(2);
    start_op(32'h4000, 32'd4, 16'd20);
    idle(5);
    base_addr_i = 32'h9000;
    len_i = 16'd3;
    start_i = 1'b1;
    idle(1);
    start_i = 1'b0;
    idle(18);
    @(negedge clk_i);
    chk("bp_grants", grants, 32'd10);
    chk("bp_req_low", {31'b0, tcdm_req_o.req}, 32'd0);
    chk("bp_valid", {31'b0, valid_o}, 32'd1);
    chk("bp_addrs_pending", exp_addr.size(), 32'd10);
    @(posedge clk_i);
    #1;
    rdy_mode = 1;
    wait_done(100);
    chk("bp_total_grants", grants, 32'd20);
    chk("bp_words_left", exp_data.size(), 32'd0);
    idle(2);

    // Address wrap.
    start_op(32'hFFFF_FFF8, 32'd8, 16'd3);
    wait_done(40);
    chk("wrap_add_c1", r_add1, 32'hFFFF_FFF8);
    chk("wrap_addrs_left", exp_addr.size(), 32'd0);
    chk("wrap_words_left", exp_data.size(), 32'd0);
    idle(2);

    // Response error on word index 2 is sticky until the next start.
    opc_idx = 2;
    start_op(32'h3000, 32'd4, 16'd5);
    wait_done(40);
    chk("opc_err_at_done", {31'b0, r_err_done}, 32'd1);
    chk("opc_words_left", exp_data.size(), 32'd0);
    opc_idx = -1;
    idle(3);
    @(negedge clk_i);
    chk("opc_err_sticky", {31'b0, err_o}, 32'd1);
    @(posedge clk_i);
    #1;
    start_op(32'h3100, 32'd4, 16'd2);
    wait_done(40);
    chk("opc_err_cleared", {31'b0, r_err1}, 32'd0);
    chk("opc_err_clean_run", {31'b0, r_err_done}, 32'd0);
    idle(2);

    // Reset while a request is in flight.
    start_op(32'h5000, 32'd4, 16'd6);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    exp_data.delete();
    exp_addr.delete();
    @(negedge clk_i);
    chk("mrst_busy", {31'b0, busy_o}, 32'd0);
    chk("mrst_done", {31'b0, done_o}, 32'd0);
    chk("mrst_valid", {31'b0, valid_o}, 32'd0);
    chk("mrst_data", data_o, 32'd0);
    chk("mrst_req", {31'b0, tcdm_req_o.req}, 32'd0);
    chk("mrst_add", tcdm_req_o.add, 32'd0);
    @(negedge clk_i);
    chk("mrst_err_after_stale", {31'b0, err_o}, 32'd0);
    chk("mrst_valid_after_stale", {31'b0, valid_o}, 32'd0);
    @(posedge clk_i);
    #1;
    idle(2);

    // Randomized operations with random grant and ready.
    gnt_mode = 1;
    rdy_mode = 2;
    idle(2);
    for (int k = 0; k < 10; k++) begin
      l = 16'($urandom_range(0, 24));
      s = (k % 3 == 0) ? $urandom : 32'(4 * $urandom_range(0, 8));
      start_op($urandom, s, l);
      wait_done(int'(l) * 30 + 40);
      chk("rand_err", {31'b0, r_err_done}, 32'd0);
      chk("rand_words_left", exp_data.size(), 32'd0);
      chk("rand_addrs_left", exp_addr.size(), 32'd0);
      idle($urandom_range(1, 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
